tdm_demux: RTL and testbench
============================

Name: tdm_demux

Overview:
Receive-side counterpart of the team's 2-to-1 mux datapath: takes a time-division-multiplexed word stream (one channel per slot, frame marked by sync) and distributes each slot to its own registered channel output. Sits at the receive end of a mux-driven serial/TDM link. Whole frames are assembled in a shadow buffer and released atomically with a one-cycle frame_valid strobe. Frame alignment is tracked with a HUNT/LOCKED state machine and sync-error detection.

Parameters:
CHANNELS, 4, number of TDM slots per frame (>= 2); slot k maps to channel k
WIDTH, 8, bits per slot word
SW, $clog2(CHANNELS), slot counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
en  input  1  slot-valid / enable; din and sync sampled only when en=1
sync  input  1  frame marker; high with en on slot 0 of every frame
din  input  WIDTH  slot data word
ch_out  output  CHANNELS*WIDTH  last complete frame; channel k at ch_out[k*WIDTH +: WIDTH]
frame_valid  output  1  one-cycle pulse when ch_out is updated
locked  output  1  1 while in LOCKED state
slot  output  SW  index of next slot expected (0 in HUNT)
sync_err  output  1  one-cycle pulse on alignment error

Behaviour:
- All state updates on rising clk; rst sampled on clk only. Reset: state=HUNT, slot=0, shadow=0, ch_out=0, frame_valid=0, sync_err=0, locked=0.
- en=0: full stall; no register changes except frame_valid and sync_err, which return to 0.
- HUNT, en=1, sync=0: din discarded, stay HUNT.
- HUNT, en=1, sync=1: shadow[0]<=din, slot<=1, go LOCKED (locked=1 next cycle).
- LOCKED, en=1, sync=0, 0<slot<CHANNELS-1: shadow[slot]<=din, slot<=slot+1.
- LOCKED, en=1, sync=0, slot=CHANNELS-1 (last slot): same edge ch_out<={din, shadow[CHANNELS-2:0]}, frame_valid<=1, slot<=0. Latency: ch_out/frame_valid visible the cycle after the last slot is presented.
- LOCKED, en=1, sync=1, slot=0: normal frame start; shadow[0]<=din, slot<=1.
- LOCKED, en=1, sync=1, slot!=0 (early sync): sync_err<=1, partial frame discarded (ch_out unchanged, no frame_valid), realign: shadow[0]<=din, slot<=1, stay LOCKED.
- LOCKED, en=1, sync=0, slot=0 (missing sync): sync_err<=1, din discarded, go HUNT, slot<=0.
- sync on the last slot is early-sync (slot!=0): error takes priority; no frame_valid.
- ch_out holds its value until the next complete frame; stale shadow entries are never exposed except via a full frame write.
- rst mid-frame: partial frame dropped, ch_out cleared to 0, state HUNT on the next cycle.
- Slot counter wraps CHANNELS-1 -> 0 only via the last-slot rule; non-power-of-2 CHANNELS never reaches unused codes.

Test Plan:
- Reset then en=1, sync=1 with din=8'hA0, then A1, A2, A3 (sync=0) -> frame_valid pulses one cycle after A3; ch_out=32'hA3A2A1A0; locked=1, slot=0.
- Two back-to-back frames 10..13, 20..23 with en held high -> two frame_valid pulses 4 cycles apart; ch_out=32'h13121110 then 32'h23222120.
- Frame with en=0 for 3 cycles between slots 1 and 2 -> slot holds at 2, no output change; frame completes with correct ch_out, frame_valid only after slot 3.
- Locked, sync=1 at slot 2 with din=8'h55 -> sync_err pulses, ch_out unchanged, slot=1; next frame completes with channel 0 = 8'h55.
- Locked, slot=0 presented with sync=0 -> sync_err pulses, locked=0, slot=0; data ignored until next sync.
- rst asserted after slot 2 of a frame -> next cycle ch_out=0, locked=0, frame_valid=0; a fresh full frame decodes correctly.

Source files
------------

// File: rtl/tdm_demux.sv
// Receive-side TDM demultiplexer: collects one word per slot into a shadow buffer
// and releases each complete frame atomically on ch_out with a frame_valid strobe.
module tdm_demux #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  localparam int SW      = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      sync,
  input  logic [WIDTH-1:0]          din,
  output logic [CHANNELS*WIDTH-1:0] ch_out,
  output logic                      frame_valid,
  output logic                      locked,
  output logic [SW-1:0]             slot,
  output logic                      sync_err
);

  localparam logic [0:0]    HUNT   = 1'b0;
  localparam logic [0:0]    LOCKED = 1'b1;
  localparam logic [SW-1:0] LAST   = SW'(CHANNELS - 1);

  logic [0:0]       state;
  // The last slot is never stored; it goes straight to ch_out with the shadow.
  logic [WIDTH-1:0] shadow [CHANNELS-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      slot        <= '0;
      ch_out      <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      for (int unsigned k = 0; k < CHANNELS - 1; k++) shadow[k] <= '0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (en) begin
        case (state)
          HUNT: begin
            if (sync) begin
              shadow[0] <= din;
              slot      <= SW'(1);
              state     <= LOCKED;
            end
          end
          default: begin
            if (sync) begin
              // Early sync (including on the last slot) drops the partial frame.
              if (slot != '0) sync_err <= 1'b1;
              shadow[0] <= din;
              slot      <= SW'(1);
            end else if (slot == '0) begin
              sync_err <= 1'b1;
              state    <= HUNT;
            end else if (slot == LAST) begin
              ch_out[(CHANNELS-1)*WIDTH +: WIDTH] <= din;
              for (int unsigned k = 0; k < CHANNELS - 1; k++)
                ch_out[k*WIDTH +: WIDTH] <= shadow[k];
              frame_valid <= 1'b1;
              slot        <= '0;
            end else begin
              shadow[slot] <= din;
              slot         <= slot + SW'(1);
            end
          end
        endcase
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux.sv
// Directed and randomized bench for tdm_demux against a queue-based frame model.
module tb_tdm_demux;

  localparam int CH = 4;
  localparam int W  = 8;
  localparam int SWB = $clog2(CH);

  logic              clk = 1'b0;
  logic              rst, en, sync;
  logic [W-1:0]      din;
  logic [CH*W-1:0]   ch_out;
  logic              frame_valid, locked, sync_err;
  logic [SWB-1:0]    slot;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: words of the frame in progress, alignment flag, last frame.
  logic [W-1:0]    part_q[$];
  bit              m_locked;
  logic [CH*W-1:0] m_ch;
  bit              m_fv, m_err;

  tdm_demux #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .din(din),
    .ch_out(ch_out), .frame_valid(frame_valid), .locked(locked),
    .slot(slot), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit e, input bit s, input logic [W-1:0] d);
    m_fv  = 0;
    m_err = 0;
    if (r) begin
      part_q.delete();
      m_locked = 0;
      m_ch     = '0;
    end else if (e) begin
      if (s) begin
        if (m_locked && part_q.size() != 0) m_err = 1;
        part_q.delete();
        part_q.push_back(d);
        m_locked = 1;
      end else if (m_locked) begin
        if (part_q.size() == 0) begin
          m_err    = 1;
          m_locked = 0;
        end else begin
          part_q.push_back(d);
          if (part_q.size() == CH) begin
            for (int k = 0; k < CH; k++) m_ch[k*W +: W] = part_q[k];
            m_fv = 1;
            part_q.delete();
          end
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit s, input logic [W-1:0] d);
    rst = r; en = e; sync = s; din = d;
    @(posedge clk);
    #1;
    model(r, e, s, d);
    check("ch_out", 64'(ch_out), 64'(m_ch));
    check("frame_valid", 64'(frame_valid), 64'(m_fv));
    check("locked", 64'(locked), 64'(m_locked));
    check("slot", 64'(slot), 64'(part_q.size()));
    check("sync_err", 64'(sync_err), 64'(m_err));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sync = 1'b0; din = '0;
    m_locked = 0; m_ch = '0; m_fv = 0; m_err = 0;
    @(negedge clk);
    cyc(1, 0, 0, 8'h00);
    cyc(1, 1, 1, 8'hFF);
    check("reset_ch_out", 64'(ch_out), 64'h0);

    // First frame A0..A3
    cyc(0, 1, 1, 8'hA0);
    cyc(0, 1, 0, 8'hA1);
    cyc(0, 1, 0, 8'hA2);
    cyc(0, 1, 0, 8'hA3);
    check("first_frame", 64'(ch_out), 64'hA3A2A1A0);

    // Back-to-back frames
    for (int f = 1; f <= 2; f++)
      for (int k = 0; k < CH; k++) cyc(0, 1, k == 0, 8'(f*16 + k));
    check("b2b_frame", 64'(ch_out), 64'h23222120);

    // Stall between slots 1 and 2
    cyc(0, 1, 1, 8'h30);
    cyc(0, 1, 0, 8'h31);
    for (int i = 0; i < 3; i++) cyc(0, 0, i == 1, 8'hEE);
    check("stall_slot", 64'(slot), 64'd2);
    cyc(0, 1, 0, 8'h32);
    cyc(0, 1, 0, 8'h33);

    // Early sync at slot 2, then realigned frame
    cyc(0, 1, 1, 8'h40);
    cyc(0, 1, 0, 8'h41);
    cyc(0, 1, 1, 8'h55);
    cyc(0, 1, 0, 8'h56);
    cyc(0, 1, 0, 8'h57);
    cyc(0, 1, 0, 8'h58);
    check("realign_ch0", 64'(ch_out[W-1:0]), 64'h55);

    // Sync on last slot is an error, not a frame
    cyc(0, 1, 1, 8'h01);
    cyc(0, 1, 0, 8'h02);
    cyc(0, 1, 0, 8'h03);
    cyc(0, 1, 1, 8'h04);
    cyc(0, 1, 0, 8'h05);
    cyc(0, 1, 0, 8'h06);
    cyc(0, 1, 0, 8'h07);

    // Missing sync drops to hunt; data ignored until sync
    cyc(0, 1, 0, 8'h99);
    cyc(0, 1, 0, 8'h77);
    for (int k = 0; k < CH; k++) cyc(0, 1, k == 0, 8'(8'h60 + k));

    // Reset mid-frame
    cyc(0, 1, 1, 8'h70);
    cyc(0, 1, 0, 8'h71);
    cyc(0, 1, 0, 8'h72);
    cyc(1, 1, 0, 8'h73);
    for (int k = 0; k < CH; k++) cyc(0, 1, k == 0, 8'(8'h80 + k));
    check("post_rst_frame", 64'(ch_out), 64'h83828180);

    // Randomized traffic, mostly well-formed with injected faults
    for (int i = 0; i < 600; i++) begin
      bit r, e, s;
      r = ($urandom_range(0, 149) == 0);
      e = ($urandom_range(0, 4) != 0);
      s = (part_q.size() == 0 && $urandom_range(0, 7) != 0) || ($urandom_range(0, 19) == 0);
      cyc(r, e, s, 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
